// File: rtl/traffic_pkg.sv
// Shared types and defaults for the vehicle-detect conditioner.
package traffic_pkg;

  // Per-channel demand FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_SERVING = 2'd2
  } chan_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int WAIT_MAX_DEF        = 31;

  localparam int WAIT_W   = 5;  // width of the wait counters
  localparam int DB_CNT_W = 4;  // enough for a debounce length up to 15

  localparam int CH_NS = 0;
  localparam int CH_EW = 1;
  localparam int NUM_CH = 2;

  localparam logic [WAIT_W-1:0] WAIT_ONE = 1;

  // Saturating increment used by the wait counters.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v,
                                                input logic [WAIT_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + WAIT_ONE;
  endfunction

endpackage

// File: rtl/vehicle_detect_conditioner_if.sv
// Sensor, lamp-feedback and conditioned-demand signals of the conditioner.
interface vehicle_detect_conditioner_if;
  import traffic_pkg::*;

  logic              ns_loop_raw;
  logic              ew_loop_raw;
  logic              ns_green;
  logic              ew_green;
  logic              NS_VEHICLE_DETECT;
  logic              EW_VEHICLE_DETECT;
  logic [WAIT_W-1:0] ns_wait;
  logic [WAIT_W-1:0] ew_wait;
  logic              conflict;

  // Environment side: drives sensors and lamps, observes demands.
  modport master (
    output ns_loop_raw, ew_loop_raw, ns_green, ew_green,
    input  NS_VEHICLE_DETECT, EW_VEHICLE_DETECT, ns_wait, ew_wait, conflict
  );

  // Conditioner side.
  modport slave (
    input  ns_loop_raw, ew_loop_raw, ns_green, ew_green,
    output NS_VEHICLE_DETECT, EW_VEHICLE_DETECT, ns_wait, ew_wait, conflict
  );
endinterface

// File: rtl/detect_channel.sv
// One approach: synchronizer, debouncer, demand FSM and wait counter.
module detect_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int WAIT_MAX        = WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loop_raw_i,
  input  logic              green_i,
  output logic              detect_o,
  output logic [WAIT_W-1:0] wait_o
);

  localparam logic [DB_CNT_W-1:0] DB_LAST    = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_CNT_W-1:0] DB_ONE     = 1;
  localparam logic [WAIT_W-1:0]   WAIT_MAX_V = WAIT_W'(WAIT_MAX);

  logic                sync1_q, sync2_q;
  logic                filt_q, filt_d;
  logic [DB_CNT_W-1:0] db_cnt_q, db_cnt_d;
  chan_state_e         state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  // Two-flop synchronizer for the asynchronous loop level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= loop_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles, flip the level on the last one.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == DB_LAST) begin
        filt_d = ~filt_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end
  end

  // Demand FSM: latch a demand until own green serves it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (filt_q && !green_i) state_d = ST_WAITING;
      ST_WAITING: if (green_i) state_d = ST_SERVING;
      ST_SERVING: if (!green_i) state_d = filt_q ? ST_WAITING : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Wait counter runs only while the FSM stays in WAITING; any exit clears it.
  always_comb begin
    wait_d = '0;
    if (state_q == ST_WAITING && state_d == ST_WAITING) begin
      wait_d = sat_inc(wait_q, WAIT_MAX_V);
    end
  end

  // State registers for debouncer, FSM and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= ST_IDLE;
      wait_q   <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      wait_q   <= wait_d;
    end
  end

  assign detect_o = (state_q == ST_WAITING) | filt_q;
  assign wait_o   = wait_q;

endmodule

// File: rtl/vehicle_detect_conditioner.sv
// Two independent detect channels (NS, EW) plus a sticky green-conflict flag.
module vehicle_detect_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int WAIT_MAX        = WAIT_MAX_DEF
) (
  input logic clk,
  input logic rst_n,
  vehicle_detect_conditioner_if.slave bus
);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] green;
  logic [NUM_CH-1:0] detect;
  logic [WAIT_W-1:0] wait_cnt [NUM_CH];
  logic              conflict_q, conflict_d;

  assign raw[CH_NS]   = bus.ns_loop_raw;
  assign raw[CH_EW]   = bus.ew_loop_raw;
  assign green[CH_NS] = bus.ns_green;
  assign green[CH_EW] = bus.ew_green;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    detect_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .WAIT_MAX       (WAIT_MAX)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .loop_raw_i(raw[gi]),
      .green_i   (green[gi]),
      .detect_o  (detect[gi]),
      .wait_o    (wait_cnt[gi])
    );
  end

  // Conflict is observed only; it never feeds back into the channels.
  always_comb begin
    conflict_d = conflict_q | (bus.ns_green & bus.ew_green);
  end

  // Sticky conflict register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign bus.NS_VEHICLE_DETECT = detect[CH_NS];
  assign bus.EW_VEHICLE_DETECT = detect[CH_EW];
  assign bus.ns_wait           = wait_cnt[CH_NS];
  assign bus.ew_wait           = wait_cnt[CH_EW];
  assign bus.conflict          = conflict_q;

endmodule

// File: tb/tb_vehicle_detect_conditioner.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_vehicle_detect_conditioner;

  localparam int DB   = 4;
  localparam int WMAX = 31;
  localparam int M_IDLE = 0, M_WAITING = 1, M_SERVING = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vehicle_detect_conditioner_if bus ();

  vehicle_detect_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .WAIT_MAX       (WMAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  // Behavioural model: raw sample history (bit 0 = newest), filtered level,
  // demand state, wait count, conflict flag.
  logic [63:0] m_hist [2];
  bit          m_filt [2];
  int          m_state[2];
  int          m_wait [2];
  bit          m_conflict;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_hist[c]  = '0;
      m_filt[c]  = 1'b0;
      m_state[c] = M_IDLE;
      m_wait[c]  = 0;
    end
    m_conflict = 1'b0;
  endtask

  function automatic bit exp_det(input int c);
    return (m_state[c] == M_WAITING) || m_filt[c];
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit raw, grn, all_diff, new_filt;
    int nxt;
    for (int c = 0; c < 2; c++) begin
      raw = (c == 0) ? bus.ns_loop_raw : bus.ew_loop_raw;
      grn = (c == 0) ? bus.ns_green    : bus.ew_green;
      // The level seen by the debouncer lags raw by two edges; it flips once
      // the last DB such samples all disagree with the current level.
      all_diff = 1'b1;
      for (int k = 1; k <= DB; k++)
        if (m_hist[c][k] == m_filt[c]) all_diff = 1'b0;
      new_filt = all_diff ? !m_filt[c] : m_filt[c];
      nxt = m_state[c];
      if (m_state[c] == M_IDLE && m_filt[c] && !grn) nxt = M_WAITING;
      else if (m_state[c] == M_WAITING && grn) nxt = M_SERVING;
      else if (m_state[c] == M_SERVING && !grn) nxt = m_filt[c] ? M_WAITING : M_IDLE;
      if (m_state[c] == M_WAITING && nxt == M_WAITING)
        m_wait[c] = (m_wait[c] + 1 > WMAX) ? WMAX : m_wait[c] + 1;
      else
        m_wait[c] = 0;
      m_state[c] = nxt;
      m_filt[c]  = new_filt;
      m_hist[c]  = {m_hist[c][62:0], raw};
    end
    if (bus.ns_green && bus.ew_green) m_conflict = 1'b1;
  endtask

  task automatic compare_all();
    check_eq("ns_detect", {31'd0, bus.NS_VEHICLE_DETECT}, {31'd0, exp_det(0)});
    check_eq("ew_detect", {31'd0, bus.EW_VEHICLE_DETECT}, {31'd0, exp_det(1)});
    check_eq("ns_wait",   {27'd0, bus.ns_wait}, m_wait[0]);
    check_eq("ew_wait",   {27'd0, bus.ew_wait}, m_wait[1]);
    check_eq("conflict",  {31'd0, bus.conflict}, {31'd0, m_conflict});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare_all();
    if (verbose)
      $display("t=%0t rst_n=%b raw=%b%b grn=%b%b -> det=%b%b wait=%0d/%0d conflict=%b",
               $time, rst_n, bus.ns_loop_raw, bus.ew_loop_raw, bus.ns_green, bus.ew_green,
               bus.NS_VEHICLE_DETECT, bus.EW_VEHICLE_DETECT, bus.ns_wait, bus.ew_wait,
               bus.conflict);
  endtask

  // Assert reset between edges and check that everything clears without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_ns_detect", {31'd0, bus.NS_VEHICLE_DETECT}, 0);
    check_eq("async_rst_ew_detect", {31'd0, bus.EW_VEHICLE_DETECT}, 0);
    check_eq("async_rst_ns_wait",   {27'd0, bus.ns_wait}, 0);
    check_eq("async_rst_ew_wait",   {27'd0, bus.ew_wait}, 0);
    check_eq("async_rst_conflict",  {31'd0, bus.conflict}, 0);
    if (verbose) $display("t=%0t asynchronous reset asserted", $time);
  endtask

  int ns_hold, ew_hold, ng_hold, eg_hold;

  initial begin
    rst_n = 1'b0;
    bus.ns_loop_raw = 1'b0;
    bus.ew_loop_raw = 1'b0;
    bus.ns_green    = 1'b0;
    bus.ew_green    = 1'b0;
    model_reset();

    // Reset state and first-detect latency.
    repeat (3) tick();
    check_eq("reset_conflict", {31'd0, bus.conflict}, 0);
    rst_n = 1'b1;
    bus.ns_loop_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq($sformatf("ns_latency_edge%0d", i), {31'd0, bus.NS_VEHICLE_DETECT},
               (i == 6) ? 1 : 0);
      check_eq("ew_quiet", {31'd0, bus.EW_VEHICLE_DETECT}, 0);
    end

    // Latching with a short EW glitch running alongside.
    repeat (4) tick();
    bus.ns_loop_raw = 1'b0;
    bus.ew_loop_raw = 1'b1;
    repeat (3) tick();
    bus.ew_loop_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("ew_glitch_detect", {31'd0, bus.EW_VEHICLE_DETECT}, 0);
      check_eq("ew_glitch_wait",   {27'd0, bus.ew_wait}, 0);
    end
    repeat (30) tick();
    check_eq("ns_latched", {31'd0, bus.NS_VEHICLE_DETECT}, 1);
    check_eq("ns_wait_sat", {27'd0, bus.ns_wait}, WMAX);
    bus.ns_green = 1'b1;
    tick();
    check_eq("ns_wait_clr_on_serve", {27'd0, bus.ns_wait}, 0);
    repeat (2) tick();
    bus.ns_green = 1'b0;
    tick();
    check_eq("ns_detect_released", {31'd0, bus.NS_VEHICLE_DETECT}, 0);

    // Re-arm: car still present when green falls.
    bus.ns_loop_raw = 1'b1;
    repeat (8) tick();
    bus.ns_green = 1'b1;
    repeat (3) tick();
    bus.ns_green = 1'b0;
    tick();
    check_eq("rearm_detect", {31'd0, bus.NS_VEHICLE_DETECT}, 1);
    check_eq("rearm_wait0",  {27'd0, bus.ns_wait}, 0);
    tick();
    check_eq("rearm_wait1",  {27'd0, bus.ns_wait}, 1);

    // Conflict is sticky, then reset mid-cycle.
    bus.ns_green = 1'b1;
    bus.ew_green = 1'b1;
    tick();
    check_eq("conflict_set", {31'd0, bus.conflict}, 1);
    bus.ns_green = 1'b0;
    bus.ew_green = 1'b0;
    repeat (3) tick();
    check_eq("conflict_sticky", {31'd0, bus.conflict}, 1);
    check_eq("pre_reset_ns_detect", {31'd0, bus.NS_VEHICLE_DETECT}, 1);
    async_reset();
    repeat (2) tick();
    #2 rst_n = 1'b1;

    // Random traffic.
    verbose = 1'b0;
    ns_hold = 0; ew_hold = 0; ng_hold = 0; eg_hold = 0;
    for (int b = 0; b < 20; b++) begin
      if (b > 0 && $urandom_range(3) == 0) begin
        async_reset();
        repeat ($urandom_range(3)) tick();
        #2 rst_n = 1'b1;
      end
      for (int t = 0; t < 100; t++) begin
        if (ns_hold == 0) begin bus.ns_loop_raw = 1'($urandom_range(1)); ns_hold = $urandom_range(10, 1); end
        if (ew_hold == 0) begin bus.ew_loop_raw = 1'($urandom_range(1)); ew_hold = $urandom_range(10, 1); end
        if (ng_hold == 0) begin bus.ns_green = 1'($urandom_range(1)); ng_hold = $urandom_range(25, 1); end
        if (eg_hold == 0) begin
          bus.ew_green = 1'($urandom_range(1));
          if (bus.ns_green && bus.ew_green && $urandom_range(19) != 0) bus.ew_green = 1'b0;
          eg_hold = $urandom_range(25, 1);
        end
        ns_hold--; ew_hold--; ng_hold--; eg_hold--;
        tick();
      end
      $display("burst %0d done: det=%b%b wait=%0d/%0d conflict=%b checks=%0d",
               b, bus.NS_VEHICLE_DETECT, bus.EW_VEHICLE_DETECT, bus.ns_wait, bus.ew_wait,
               bus.conflict, n_checks);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
